// File: rtl/spy_buffer_trig.sv
// Circular capture buffer with trigger-and-stop and registered read-back port.
// Optional macro SPY_TIMESTAMP_EN stores {timestamp, data} words instead of bare data.
module spy_buffer_trig #(
   parameter int unsigned DATA_W = 24,
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned TS_W   = 16,
`ifdef SPY_TIMESTAMP_EN
   localparam int unsigned TS_BITS = TS_W,
`else
   localparam int unsigned TS_BITS = 0 * TS_W,
`endif
   localparam int unsigned WORD_W = DATA_W + TS_BITS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic [DATA_W-1:0] data_in,
   input  logic              dv,
   input  logic              freeze,
   input  logic              trig,
   input  logic              trig_en,
   input  logic [ADDR_W-1:0] post_cnt,
   input  logic              rearm,
   input  logic [ADDR_W-1:0] addr,
   input  logic              rd_en,
   output logic [ADDR_W-1:0] last_pos,
   output logic              wrapped,
   output logic [ADDR_W-1:0] trig_pos,
   output logic              frozen,
   output logic [WORD_W-1:0] data_out
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [1:0] S_RUN    = 2'd0;
   localparam logic [1:0] S_POST   = 2'd1;
   localparam logic [1:0] S_FROZEN = 2'd2;
   localparam logic [ADDR_W-1:0] POS_MAX = '1;

   logic [1:0]        state, state_nxt;
   logic [ADDR_W-1:0] pos, pos_nxt;
   logic [ADDR_W-1:0] trig_pos_nxt;
   logic [ADDR_W-1:0] remaining, remaining_nxt;
   logic              wrapped_nxt;
   logic              we_c;
   logic [WORD_W-1:0] word_c;
   logic [WORD_W-1:0] ram [DEPTH];

`ifdef SPY_TIMESTAMP_EN
   logic [TS_W-1:0] ts;

   // Free-running cycle stamp, restarted by reset or clr.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)    ts <= '0;
      else if (clr) ts <= '0;
      else          ts <= ts + TS_W'(1);
   end

   assign word_c = {ts, data_in};
`else
   assign word_c = data_in;
`endif

   // Next-state logic: clr dominates, then per-state trigger/post/rearm handling.
   always_comb begin
      state_nxt     = state;
      pos_nxt       = pos;
      wrapped_nxt   = wrapped;
      trig_pos_nxt  = trig_pos;
      remaining_nxt = remaining;
      we_c          = dv & ~freeze & (state != S_FROZEN) & ~clr;
      if (clr) begin
         state_nxt     = S_RUN;
         pos_nxt       = '0;
         wrapped_nxt   = 1'b0;
         trig_pos_nxt  = '0;
         remaining_nxt = '0;
      end else begin
         case (state)
            S_RUN: begin
               if (trig & trig_en) begin
                  trig_pos_nxt  = pos;
                  remaining_nxt = post_cnt;
                  state_nxt     = (post_cnt == '0) ? S_FROZEN : S_POST;
               end
            end
            S_POST: begin
               if (we_c) begin
                  remaining_nxt = remaining - ADDR_W'(1);
                  if (remaining == ADDR_W'(1)) state_nxt = S_FROZEN;
               end
            end
            S_FROZEN: begin
               if (rearm) state_nxt = S_RUN;
            end
            default: state_nxt = S_RUN;
         endcase
         if (we_c) begin
            pos_nxt = pos + ADDR_W'(1);
            if (pos == POS_MAX) wrapped_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_RUN;
         pos       <= '0;
         wrapped   <= 1'b0;
         trig_pos  <= '0;
         remaining <= '0;
         frozen    <= 1'b0;
      end else begin
         state     <= state_nxt;
         pos       <= pos_nxt;
         wrapped   <= wrapped_nxt;
         trig_pos  <= trig_pos_nxt;
         remaining <= remaining_nxt;
         frozen    <= (state_nxt == S_FROZEN);
      end
   end

   // Capture RAM: single write port, no reset, so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we_c) ram[pos] <= word_c;
   end

   // Registered read, read-first against a same-cycle write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)      data_out <= '0;
      else if (rd_en) data_out <= ram[addr];
   end

   assign last_pos = pos;

endmodule

// File: tb/tb_spy_buffer_trig.sv
// Bench for spy_buffer_trig: directed scenarios plus random traffic against a behavioural model.
// Honours SPY_TIMESTAMP_EN the same way as the design.
module tb_spy_buffer_trig;

   localparam int unsigned DATA_W = 24;
   localparam int unsigned ADDR_W = 11;
   localparam int unsigned TS_W   = 16;
   localparam int unsigned DEPTH  = 2 ** ADDR_W;
`ifdef SPY_TIMESTAMP_EN
   localparam int unsigned TS_BITS = TS_W;
`else
   localparam int unsigned TS_BITS = 0;
`endif
   localparam int unsigned WORD_W = DATA_W + TS_BITS;

   logic              clk = 1'b0;
   logic              reset, clr, dv, freeze, trig, trig_en, rearm, rd_en;
   logic [DATA_W-1:0] data_in;
   logic [ADDR_W-1:0] post_cnt, addr;
   logic [ADDR_W-1:0] last_pos, trig_pos;
   logic              wrapped, frozen;
   logic [WORD_W-1:0] data_out;

   spy_buffer_trig #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TS_W(TS_W)) dut (
      .clk(clk), .reset(reset), .clr(clr), .data_in(data_in), .dv(dv),
      .freeze(freeze), .trig(trig), .trig_en(trig_en), .post_cnt(post_cnt),
      .rearm(rearm), .addr(addr), .rd_en(rd_en), .last_pos(last_pos),
      .wrapped(wrapped), .trig_pos(trig_pos), .frozen(frozen), .data_out(data_out)
   );

   always #5 clk = ~clk;

   // Behavioural model
   int unsigned       m_pos, m_tp, m_left, m_ts;
   bit                m_wrap, m_frz, m_post, m_dknown;
   logic [WORD_W-1:0] m_mem [DEPTH];
   bit                m_wr  [DEPTH];
   logic [WORD_W-1:0] m_dout;
   int                n_vec = 0;
   int                n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [WORD_W-1:0] mk_word();
`ifdef SPY_TIMESTAMP_EN
      return {TS_W'(m_ts), data_in};
`else
      return data_in;
`endif
   endfunction

   task automatic model_reset();
      m_pos = 0; m_tp = 0; m_left = 0; m_ts = 0;
      m_wrap = 0; m_frz = 0; m_post = 0;
      m_dout = '0; m_dknown = 1;
   endtask

   // One clock of the model, evaluated with the inputs about to be sampled.
   task automatic model_step();
      bit w;
      if (rd_en) begin
         if (m_wr[addr]) begin m_dout = m_mem[addr]; m_dknown = 1; end
         else m_dknown = 0;
      end
      if (clr) begin
         m_pos = 0; m_tp = 0; m_left = 0; m_ts = 0;
         m_wrap = 0; m_frz = 0; m_post = 0;
         return;
      end
      w = dv && !freeze && !m_frz;
      if (m_frz) begin
         if (rearm) m_frz = 0;
      end else if (m_post) begin
         if (w) begin
            m_left--;
            if (m_left == 0) begin m_post = 0; m_frz = 1; end
         end
      end else if (trig && trig_en) begin
         m_tp = m_pos;
         if (post_cnt == 0) m_frz = 1;
         else begin m_post = 1; m_left = post_cnt; end
      end
      if (w) begin
         m_mem[m_pos] = mk_word();
         m_wr[m_pos]  = 1;
         if (m_pos == DEPTH - 1) m_wrap = 1;
         m_pos = (m_pos + 1) % DEPTH;
      end
      m_ts++;
   endtask

   task automatic compare_all();
      check("last_pos", 64'(last_pos), 64'(m_pos));
      check("wrapped",  64'(wrapped),  64'(m_wrap));
      check("trig_pos", 64'(trig_pos), 64'(m_tp));
      check("frozen",   64'(frozen),   64'(m_frz));
      if (m_dknown) check("data_out", 64'(data_out), 64'(m_dout));
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic set_idle();
      clr = 0; dv = 0; freeze = 0; trig = 0; trig_en = 0; rearm = 0; rd_en = 0;
      data_in = '0; post_cnt = '0; addr = '0;
   endtask

   // Asserts reset between edges and checks the outputs clear before the next edge.
   task automatic mid_cycle_reset();
      set_idle();
      #3;
      reset = 1;
      #1;
      model_reset();
      compare_all();
      @(posedge clk);
      #1;
      reset = 0;
   endtask

   task automatic write_n(input int n);
      dv = 1;
      for (int i = 0; i < n; i++) begin
         data_in = DATA_W'($urandom);
         tick();
      end
      dv = 0;
   endtask

   initial begin
      reset = 1;
      set_idle();
      #2;
      model_reset();
      compare_all();
      @(posedge clk); @(posedge clk);
      #1;
      reset = 0;

      // Free-running wrap
      dv = 1;
      for (int i = 0; i < 2050; i++) begin
         data_in = DATA_W'(i);
         tick();
      end
      set_idle();
      check("free_last_pos", 64'(last_pos), 64'd2);
      check("free_wrapped",  64'(wrapped),  64'd1);
      rd_en = 1; addr = ADDR_W'(0);
      tick();
      check("free_rd0", 64'(data_out[DATA_W-1:0]), 64'd2048);
      addr = ADDR_W'(5);
      tick();
      check("free_rd5", 64'(data_out[DATA_W-1:0]), 64'd5);
      rd_en = 0;

      // Trigger-and-stop with post_cnt=10 at pos=100
      clr = 1; tick(); clr = 0;
      trig_en = 1;
      write_n(100);
      trig = 1; post_cnt = ADDR_W'(10); dv = 1; data_in = DATA_W'($urandom);
      tick();
      trig = 0;
      write_n(15);
      check("ts_trig_pos", 64'(trig_pos), 64'd100);
      check("ts_last_pos", 64'(last_pos), 64'd111);
      check("ts_frozen",   64'(frozen),   64'd1);

      // rearm together with trig: trigger ignored
      rearm = 1; trig = 1; post_cnt = ADDR_W'(3);
      tick();
      rearm = 0; trig = 0;
      check("rearm_frozen",   64'(frozen),   64'd0);
      check("rearm_trig_pos", 64'(trig_pos), 64'd100);

      // post_cnt=0 with and without the trigger-cycle write
      clr = 1; tick(); clr = 0;
      write_n(7);
      trig = 1; post_cnt = '0; dv = 1; data_in = DATA_W'($urandom);
      tick();
      trig = 0;
      write_n(3);
      check("p0_last_pos", 64'(last_pos), 64'd8);
      check("p0_frozen",   64'(frozen),   64'd1);
      rearm = 1; tick(); rearm = 0;
      clr = 1; tick(); clr = 0;
      write_n(7);
      trig = 1; dv = 0;
      tick();
      trig = 0;
      check("p0nd_trig_pos", 64'(trig_pos), 64'd7);
      check("p0nd_last_pos", 64'(last_pos), 64'd7);
      check("p0nd_frozen",   64'(frozen),   64'd1);

      // freeze in the middle of the post window
      rearm = 1; tick(); rearm = 0;
      clr = 1; tick(); clr = 0;
      trig = 1; post_cnt = ADDR_W'(5);
      tick();
      trig = 0;
      write_n(2);
      freeze = 1;
      write_n(20);
      freeze = 0;
      write_n(10);
      check("frz_last_pos", 64'(last_pos), 64'd5);
      check("frz_frozen",   64'(frozen),   64'd1);

      // clr during POST
      rearm = 1; tick(); rearm = 0;
      trig = 1; post_cnt = ADDR_W'(50); dv = 1;
      tick();
      trig = 0;
      write_n(5);
      clr = 1; dv = 1; tick(); clr = 0; dv = 0;
      check("clr_last_pos", 64'(last_pos), 64'd0);
      check("clr_frozen",   64'(frozen),   64'd0);
      check("clr_wrapped",  64'(wrapped),  64'd0);

      // Read-first on a same-address write
      write_n(4);
      rd_en = 1; addr = last_pos; dv = 1; data_in = DATA_W'($urandom);
      tick();
      rd_en = 0; dv = 0;

      // Async reset mid-cycle
      write_n(6);
      mid_cycle_reset();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         clr      = ($urandom_range(0, 199) == 0);
         dv       = ($urandom_range(0, 9) < 7);
         freeze   = ($urandom_range(0, 7) == 0);
         trig     = ($urandom_range(0, 19) == 0);
         trig_en  = ($urandom_range(0, 4) != 0);
         rearm    = ($urandom_range(0, 14) == 0);
         post_cnt = ADDR_W'($urandom_range(0, 30));
         rd_en    = ($urandom_range(0, 1) == 1);
         addr     = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 63));
         data_in  = DATA_W'($urandom);
         tick();
      end
      set_idle();

`ifdef SPY_TIMESTAMP_EN
      begin
         logic [ADDR_W-1:0] a0, a1;
         logic [TS_W-1:0]   t0, t1;
         mid_cycle_reset();
         for (int i = 0; i < 3; i++) tick();
         a0 = last_pos;
         write_n(1);
         for (int i = 0; i < 6; i++) tick();
         a1 = last_pos;
         write_n(1);
         rd_en = 1; addr = a0; tick();
         t0 = data_out[WORD_W-1 -: TS_W];
         addr = a1; tick();
         t1 = data_out[WORD_W-1 -: TS_W];
         rd_en = 0;
         check("ts_delta", 64'(TS_W'(t1 - t0)), 64'd7);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/spy_buffer_trig.md
Name: spy_buffer_trig

Overview:
- Parametrised successor of the 11-bit spy buffer.
- Circular capture RAM of DEPTH=2^ADDR_W words × DATA_W bits, written on dv, with a trigger-and-stop mode:
  - after a trigger, POST more words are captured, then the buffer self-freezes.
- Sits on any internal data path (hit/track streams) and is read back over the slow-control bus via addr/rd_en.

Parameters:
- DATA_W, 24, width of captured word.
- ADDR_W, 11, address width; depth = 2^ADDR_W.
- TS_W, 16, timestamp width (used only with SPY_TIMESTAMP_EN).

Ports:
- clk  in  1  capture and read clock.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear: pos, wrapped, trig_pos, state.
- data_in  in  DATA_W  word to capture.
- dv  in  1  data valid.
- freeze  in  1  external hold; blocks writes while high.
- trig  in  1  trigger pulse.
- trig_en  in  1  1 = trigger-and-stop mode; 0 = trig ignored, free-running.
- post_cnt  in  ADDR_W  words to capture after the trigger word; sampled on trigger.
- rearm  in  1  leave FROZEN and return to RUN.
- addr  in  ADDR_W  read address.
- rd_en  in  1  read enable.
- last_pos  out  ADDR_W  next write address.
- wrapped  out  1  sticky: buffer has wrapped at least once.
- trig_pos  out  ADDR_W  address of the trigger word.
- frozen  out  1  state == FROZEN.
- data_out  out  DATA_W (+TS_W)  read data.

Behaviour:
- Reset (async): pos=0, wrapped=0, trig_pos=0, state=RUN, remaining=0, data_out=0. RAM contents are not cleared.
- Write enable: we = dv & ~freeze & (state != FROZEN). On we, RAM[pos]<=word and pos<=pos+1 modulo 2^ADDR_W.
- wrapped: set on a write with pos == 2^ADDR_W-1. Sticky until reset or clr.
- State RUN:
  - trig & trig_en: trig_pos<=pos; remaining<=post_cnt.
  - Next state is FROZEN if post_cnt==0, else POST.
  - The trigger-cycle word is written if we. trig_pos is the address of that word, or of the next write if dv=0 or freeze=1.
- State POST: each write decrements remaining. A write with remaining==1 goes to FROZEN after that write. trig is ignored.
- State FROZEN:
  - No writes; pos holds. trig is ignored.
  - rearm -> RUN; pos, wrapped and trig_pos are kept.
- freeze in any state: writes and the remaining counter are paused; state is unchanged.
- Priority within one cycle: reset > clr > rearm > trig.
  - clr forces RUN, pos=0, wrapped=0, trig_pos=0, remaining=0, and blocks that cycle's write.
  - rearm and trig in the same cycle: the trig is ignored.
- rearm outside FROZEN: no effect.
- Read port:
  - rd_en=1: data_out<=RAM[addr] on the next clk edge (1-cycle latency).
  - rd_en=0: data_out holds.
  - Same-address read and write in one cycle: read-first (old data).
- Outputs are registered or direct from registers: last_pos=pos, frozen=(state==FROZEN).
- RAM must infer block RAM: no reset on the array, single write port, registered read.

Optional Feature:
- Macro: SPY_TIMESTAMP_EN.
- Defined:
  - A TS_W-bit free-running cycle counter increments every clk. It is reset to 0 by reset or clr and wraps modulo 2^TS_W.
  - Each stored word is {ts, data_in}, so the RAM and data_out are DATA_W+TS_W wide, with the timestamp in the MSBs.
- Undefined: no counter; RAM and data_out are DATA_W wide.

Test Plan:
- Free-run: trig_en=0, 2050 dv writes of data=index. last_pos=2; wrapped rises on write 2048; read addr 0 after 1 cycle = 2048, addr 5 = 5.
- Trigger-and-stop: trig_en=1, post_cnt=10, trig with dv at pos=100.
  - trig_pos=100, frozen after the write at addr 110, last_pos=111.
  - Further dv does not change last_pos.
- post_cnt=0: trig with dv=1 at pos=7 writes addr 7 only, frozen next cycle, last_pos=8. Repeat with dv=0: trig_pos=7, nothing written, frozen.
- Freeze mid-POST: post_cnt=5, freeze high for 20 dv cycles after 2 post writes. Exactly 3 more writes after release, then frozen.
- Priority:
  - rearm+trig in FROZEN -> RUN, trig_pos unchanged.
  - clr during POST -> pos=0, state RUN, wrapped=0.
  - Async reset asserted mid-cycle clears outputs before the next edge.
- With SPY_TIMESTAMP_EN: writes on cycles 3 and 10 after reset. Read TS fields differ by 7; TS wraps correctly at 2^TS_W.
